// File: rtl/reorder_tag_dispatcher.sv
// Ingress stage of the reorder path: tags each packet round-robin, forwards its words through
// one output register, limits packets in flight with release credits, and truncates oversize packets.
module reorder_tag_dispatcher #(
    parameter int unsigned TAG_WIDTH            = 6,
    parameter int unsigned CIRCULAR_BUFFER_SIZE = 50,
    parameter int unsigned DATA_WIDTH           = 64,
    parameter int unsigned MAX_TDATA_PER_PACKET = 375
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_TDATA,
    input  logic                  s_TLAST,
    input  logic                  s_TVALID,
    output logic                  s_TREADY,
    output logic [DATA_WIDTH-1:0] buffer_TDATA,
    output logic [TAG_WIDTH-1:0]  reorder_tag_in,
    output logic                  buffer_TLAST,
    output logic                  buffer_TVALID,
    input  logic                  buffer_TREADY,
    output logic                  tag_alloc_valid,
    output logic [TAG_WIDTH-1:0]  tag_alloc_tag,
    input  logic                  tag_release,
    output logic [TAG_WIDTH:0]    outstanding,
    output logic                  oversize_err,
    output logic                  release_err
);
    localparam int unsigned CNT_W = $clog2(MAX_TDATA_PER_PACKET + 1);
    localparam int unsigned OUT_W = TAG_WIDTH + 1;

    localparam logic [OUT_W-1:0]     SIZE_OUT = OUT_W'(CIRCULAR_BUFFER_SIZE);
    localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1);
    localparam logic [CNT_W-1:0]     MAX_CNT  = CNT_W'(MAX_TDATA_PER_PACKET);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [CNT_W-1:0]     word_cnt;
    logic [CNT_W-1:0]     word_cnt_nxt;
    logic [TAG_WIDTH-1:0] next_tag;
    logic [TAG_WIDTH-1:0] cur_tag;
    logic                 credit;
    logic                 out_free;
    logic                 accept;
    logic                 fwd;
    logic                 alloc;
    logic                 trunc;
    logic                 rel_ok;

    // New packets only start while a buffer slot is free; tails of truncated packets always drain.
    assign credit   = outstanding < SIZE_OUT;
    assign out_free = !buffer_TVALID || buffer_TREADY;
    assign s_TREADY = !rst && ((state == ST_DROP) ||
                               (out_free && ((state == ST_PASS) || credit)));
    assign accept   = s_TVALID && s_TREADY;
    assign fwd      = accept && (state != ST_DROP);
    assign alloc    = accept && (state == ST_IDLE);
    assign rel_ok   = tag_release && (outstanding != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Packet framing: word count, truncation at the size limit, tail discard.
    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        trunc        = 1'b0;
        if (fwd) begin
            word_cnt_nxt = (state == ST_IDLE) ? CNT_W'(1) : word_cnt + CNT_W'(1);
            if (s_TLAST) begin
                state_nxt = ST_IDLE;
            end else if (word_cnt_nxt == MAX_CNT) begin
                trunc     = 1'b1;
                state_nxt = ST_DROP;
            end else begin
                state_nxt = ST_PASS;
            end
        end else if (accept && s_TLAST) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt        <= '0;
            next_tag        <= '0;
            cur_tag         <= '0;
            outstanding     <= '0;
            tag_alloc_valid <= 1'b0;
            tag_alloc_tag   <= '0;
            oversize_err    <= 1'b0;
            release_err     <= 1'b0;
            buffer_TVALID   <= 1'b0;
            buffer_TDATA    <= '0;
            buffer_TLAST    <= 1'b0;
            reorder_tag_in  <= '0;
        end else begin
            word_cnt        <= word_cnt_nxt;
            tag_alloc_valid <= alloc;
            oversize_err    <= trunc;
            release_err     <= tag_release && (outstanding == '0);

            if (alloc) begin
                cur_tag       <= next_tag;
                tag_alloc_tag <= next_tag;
                next_tag      <= (next_tag == LAST_TAG) ? '0 : next_tag + TAG_WIDTH'(1);
            end

            if (alloc && !rel_ok) begin
                outstanding <= outstanding + OUT_W'(1);
            end else if (!alloc && rel_ok) begin
                outstanding <= outstanding - OUT_W'(1);
            end

            // Output register holds its word until the buffer takes it.
            if (fwd) begin
                buffer_TVALID  <= 1'b1;
                buffer_TDATA   <= s_TDATA;
                buffer_TLAST   <= s_TLAST || trunc;
                reorder_tag_in <= alloc ? next_tag : cur_tag;
            end else if (buffer_TREADY) begin
                buffer_TVALID  <= 1'b0;
            end
        end
    end

endmodule
